layer_op_sequencer: RTL and testbench

//  Upstream control stage for the CORDIC MAC/activation datapath. Latches the network topology on start
//  (no_layers, nl1..nl5, afl1..afl5) and walks every (layer, neuron, input) triple in order.

---
 rtl/layer_op_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_layer_op_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_op_sequencer.sv
// Control sequencer for the CORDIC MAC/activation datapath: walks every (layer, neuron, input)
// triple of a latched topology and issues one MAC op per triple over a valid/ready handshake.
module layer_op_sequencer #(
   parameter int N_W  = 6,
   parameter int WA_W = 12
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [5:0]      no_layers,
   input  logic [N_W-1:0]  nl1,
   input  logic [N_W-1:0]  nl2,
   input  logic [N_W-1:0]  nl3,
   input  logic [N_W-1:0]  nl4,
   input  logic [N_W-1:0]  nl5,
   input  logic [1:0]      afl1,
   input  logic [1:0]      afl2,
   input  logic [1:0]      afl3,
   input  logic [1:0]      afl4,
   input  logic [1:0]      afl5,
   output logic            op_valid,
   input  logic            op_ready,
   output logic [N_W-1:0]  op_in_addr,
   output logic            op_in_bank,
   output logic [WA_W-1:0] op_w_addr,
   output logic [N_W-1:0]  op_neuron,
   output logic            op_first,
   output logic            op_last,
   output logic [1:0]      op_act,
   output logic [2:0]      layer_idx,
   input  logic            nrn_done,
   output logic            busy,
   output logic            done,
   output logic            err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t          state, state_nxt;

   // Indexed by layer number; entries 0, 6 and 7 stay zero.
   logic [N_W-1:0]  nl_r  [8];
   logic [1:0]      afl_r [8];
   logic [2:0]      nlay_r;
   logic [2:0]      layer_r;
   logic [N_W-1:0]  in_idx_r;
   logic [N_W-1:0]  nrn_r;
   logic [N_W-1:0]  done_cnt_r;
   logic [WA_W-1:0] w_addr_r;
   logic            bank_r;
   logic            err_r;

   logic [N_W-1:0]  ins;
   logic [N_W-1:0]  outs;
   logic [N_W-1:0]  done_cnt_inc;
   logic            last_in;
   logic            last_op;
   logic            accept;
   logic            layer_fin;
   logic            cfg_bad;

   assign ins          = nl_r[layer_r - 3'd1];
   assign outs         = nl_r[layer_r];
   assign last_in      = (in_idx_r == ins - N_W'(1));
   assign last_op      = last_in && (nrn_r == outs - N_W'(1));
   assign accept       = (state == S_ISSUE) && op_ready;
   assign done_cnt_inc = done_cnt_r + N_W'(nrn_done);
   assign layer_fin    = (done_cnt_inc >= outs);

   // Checked on the live inputs during LOAD, the same cycle they are latched.
   always_comb begin
      cfg_bad = (no_layers < 6'd2) || (no_layers > 6'd5);
      if (nl1 == '0) cfg_bad = 1'b1;
      if (nl2 == '0) cfg_bad = 1'b1;
      if ((no_layers >= 6'd3) && (nl3 == '0)) cfg_bad = 1'b1;
      if ((no_layers >= 6'd4) && (nl4 == '0)) cfg_bad = 1'b1;
      if ((no_layers >= 6'd5) && (nl5 == '0)) cfg_bad = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = cfg_bad ? S_IDLE : S_ISSUE;
         S_ISSUE: if (accept && last_op) state_nxt = S_WAIT;
         S_WAIT:  if (layer_fin) state_nxt = (layer_r == nlay_r) ? S_DONE : S_ISSUE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 8; k++) begin
            nl_r[k]  <= '0;
            afl_r[k] <= '0;
         end
         nlay_r     <= '0;
         layer_r    <= '0;
         in_idx_r   <= '0;
         nrn_r      <= '0;
         done_cnt_r <= '0;
         w_addr_r   <= '0;
         bank_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         err_r <= 1'b0;
         case (state)
            S_LOAD: begin
               nl_r[0]    <= '0;
               nl_r[1]    <= nl1;
               nl_r[2]    <= nl2;
               nl_r[3]    <= nl3;
               nl_r[4]    <= nl4;
               nl_r[5]    <= nl5;
               nl_r[6]    <= '0;
               nl_r[7]    <= '0;
               afl_r[0]   <= '0;
               afl_r[1]   <= afl1;
               afl_r[2]   <= afl2;
               afl_r[3]   <= afl3;
               afl_r[4]   <= afl4;
               afl_r[5]   <= afl5;
               afl_r[6]   <= '0;
               afl_r[7]   <= '0;
               nlay_r     <= no_layers[2:0];
               layer_r    <= 3'd2;
               in_idx_r   <= '0;
               nrn_r      <= '0;
               done_cnt_r <= '0;
               w_addr_r   <= '0;
               bank_r     <= 1'b0;
               err_r      <= cfg_bad;
            end
            S_ISSUE: begin
               done_cnt_r <= done_cnt_inc;
               if (accept) begin
                  w_addr_r <= w_addr_r + WA_W'(1);
                  if (last_in) begin
                     in_idx_r <= '0;
                     nrn_r    <= nrn_r + N_W'(1);
                  end else begin
                     in_idx_r <= in_idx_r + N_W'(1);
                  end
               end
            end
            S_WAIT: begin
               done_cnt_r <= done_cnt_inc;
               // Weight address keeps running across layers: weights are packed with no gaps.
               if (layer_fin && (layer_r != nlay_r)) begin
                  layer_r    <= layer_r + 3'd1;
                  bank_r     <= ~bank_r;
                  in_idx_r   <= '0;
                  nrn_r      <= '0;
                  done_cnt_r <= '0;
               end
            end
            S_DONE: layer_r <= '0;
            default: ;
         endcase
      end
   end

   always_comb begin
      op_valid   = 1'b0;
      op_in_addr = '0;
      op_in_bank = 1'b0;
      op_w_addr  = '0;
      op_neuron  = '0;
      op_first   = 1'b0;
      op_last    = 1'b0;
      op_act     = '0;
      layer_idx  = '0;
      done       = 1'b0;
      busy       = (state != S_IDLE);
      err        = err_r;
      case (state)
         S_ISSUE: begin
            op_valid   = 1'b1;
            op_in_addr = in_idx_r;
            op_in_bank = bank_r;
            op_w_addr  = w_addr_r;
            op_neuron  = nrn_r;
            op_first   = (in_idx_r == '0);
            op_last    = last_in;
            op_act     = afl_r[layer_r];
            layer_idx  = layer_r;
         end
         S_WAIT:  layer_idx = layer_r;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_layer_op_sequencer.sv
// Bench for layer_op_sequencer: expected op stream is generated from nested layer/neuron/input
// loops and compared against every presented op, with randomized ready and write-back timing.
module tb_layer_op_sequencer;

   localparam int N_W  = 6;
   localparam int WA_W = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, start, op_ready, nrn_done;
   logic [5:0]      no_layers;
   logic [N_W-1:0]  nl1, nl2, nl3, nl4, nl5;
   logic [1:0]      afl1, afl2, afl3, afl4, afl5;
   logic            op_valid, op_in_bank, op_first, op_last, busy, done, err;
   logic [N_W-1:0]  op_in_addr, op_neuron;
   logic [WA_W-1:0] op_w_addr;
   logic [1:0]      op_act;
   logic [2:0]      layer_idx;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [N_W-1:0]  in_addr;
      logic            bank;
      logic [WA_W-1:0] w_addr;
      logic [N_W-1:0]  neuron;
      logic            first;
      logic            last;
      logic [1:0]      act;
   } op_t;

   op_t exp_q[$];
   int  cfg_nlay;
   int  cfg_nl[6];
   int  cfg_afl[6];
   int  mlayer, pending, delivered;

   layer_op_sequencer #(.N_W(N_W), .WA_W(WA_W)) dut (
      .clk(clk), .rst(rst), .start(start), .no_layers(no_layers),
      .nl1(nl1), .nl2(nl2), .nl3(nl3), .nl4(nl4), .nl5(nl5),
      .afl1(afl1), .afl2(afl2), .afl3(afl3), .afl4(afl4), .afl5(afl5),
      .op_valid(op_valid), .op_ready(op_ready), .op_in_addr(op_in_addr),
      .op_in_bank(op_in_bank), .op_w_addr(op_w_addr), .op_neuron(op_neuron),
      .op_first(op_first), .op_last(op_last), .op_act(op_act),
      .layer_idx(layer_idx), .nrn_done(nrn_done),
      .busy(busy), .done(done), .err(err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic set_cfg(input int nlay, input int n1, input int n2, input int n3,
                          input int n4, input int n5, input int f2, input int f3,
                          input int f4, input int f5);
      cfg_nlay = nlay;
      cfg_nl[0] = 0;  cfg_nl[1] = n1; cfg_nl[2] = n2; cfg_nl[3] = n3; cfg_nl[4] = n4; cfg_nl[5] = n5;
      cfg_afl[0] = 0; cfg_afl[1] = 0; cfg_afl[2] = f2; cfg_afl[3] = f3; cfg_afl[4] = f4; cfg_afl[5] = f5;
      no_layers = 6'(nlay);
      nl1 = N_W'(n1); nl2 = N_W'(n2); nl3 = N_W'(n3); nl4 = N_W'(n4); nl5 = N_W'(n5);
      afl1 = 2'($urandom_range(0, 3));
      afl2 = 2'(f2); afl3 = 2'(f3); afl4 = 2'(f4); afl5 = 2'(f5);
   endtask

   task automatic scramble();
      no_layers = 6'($urandom);
      nl1 = N_W'($urandom); nl2 = N_W'($urandom); nl3 = N_W'($urandom);
      nl4 = N_W'($urandom); nl5 = N_W'($urandom);
      afl2 = 2'($urandom); afl3 = 2'($urandom); afl4 = 2'($urandom); afl5 = 2'($urandom);
   endtask

   // Ops in weight-memory order: layer-major, neuron-major, input-minor.
   task automatic build_model();
      int  cnt;
      op_t o;
      exp_q.delete();
      cnt = 0;
      for (int l = 2; l <= cfg_nlay; l++)
         for (int n = 0; n < cfg_nl[l]; n++)
            for (int i = 0; i < cfg_nl[l-1]; i++) begin
               o.in_addr = N_W'(i);
               o.bank    = (l % 2 == 1);
               o.w_addr  = WA_W'(cnt % (1 << WA_W));
               o.neuron  = N_W'(n);
               o.first   = (i == 0);
               o.last    = (i == cfg_nl[l-1] - 1);
               o.act     = 2'(cfg_afl[l]);
               exp_q.push_back(o);
               cnt++;
            end
   endtask

   task automatic run_cfg(input int ready_mode, input int nrn_mode, input int abort_layer);
      bit  fin, exp_valid, exp_done, fire;
      int  hold;
      op_t h;
      build_model();
      mlayer = 2; pending = 0; delivered = 0;
      fin = 0; exp_valid = 0; exp_done = 0; hold = 0;
      nrn_done = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("load_busy", busy, 1);
      chk("load_no_valid", op_valid, 0);
      @(negedge clk);
      chk("first_op_latency", op_valid, 1);
      scramble();
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (exp_valid) chk("op_after_layer_done", op_valid, 1);
         if (exp_done)  chk("done_after_last_nrn", done, 1);
         exp_valid = 0; exp_done = 0;
         if (op_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("extra_op", op_valid, 0);
            else begin
               chk("op_fields", {op_in_addr, op_in_bank, op_w_addr, op_neuron, op_first,
                                 op_last, op_act}, exp_q[0]);
               chk("op_layer", layer_idx, mlayer);
            end
            if (abort_layer != 0 && layer_idx == 3'(abort_layer)) begin
               rst = 1'b1;
               @(negedge clk);
               chk("rst_outputs", {op_valid, busy, done, err, layer_idx, op_w_addr, op_in_addr,
                                   op_neuron, op_first, op_last, op_act, op_in_bank}, 0);
               rst = 1'b0;
               return;
            end
         end
         if (done === 1'b1) begin
            chk("done_all_ops", exp_q.size(), 0);
            chk("done_all_nrn", pending, 0);
            fin = 1;
         end
         nrn_done = 1'b0;
         fire = 0;
         if (!fin && pending > 0) begin
            if (nrn_mode == 0) fire = ($urandom_range(0, 1) == 1);
            else if (pending + delivered == cfg_nl[mlayer]) begin
               if (hold < 4) begin
                  chk("withheld_no_op", op_valid, 0);
                  hold++;
               end else fire = 1;
            end
         end
         if (fire) begin
            nrn_done = 1'b1;
            pending--;
            delivered++;
            if (delivered == cfg_nl[mlayer]) begin
               if (mlayer == cfg_nlay) exp_done = 1;
               else exp_valid = 1;
               mlayer++;
               delivered = 0;
               hold = 0;
            end
         end
         case (ready_mode)
            0:       op_ready = 1'b1;
            1:       op_ready = ~op_ready;
            default: op_ready = 1'($urandom_range(0, 1));
         endcase
         if (!fin && op_valid === 1'b1 && op_ready && exp_q.size() > 0) begin
            h = exp_q.pop_front();
            if (h.last) pending++;
         end
      end
      nrn_done = 1'b0;
      if (!fin) chk("run_timeout", fin, 1);
      @(negedge clk);
      chk("post_done_busy", busy, 0);
      chk("post_done_layer", layer_idx, 0);
      chk("done_one_cycle", done, 0);
   endtask

   task automatic run_bad(input string tag);
      int errs;
      errs = 0;
      nrn_done = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (err === 1'b1) errs++;
         chk({tag, "_no_op"}, op_valid, 0);
      end
      chk({tag, "_err_pulses"}, errs, 1);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int nl_t[6];
      rst = 1'b1; start = 1'b0; op_ready = 1'b0; nrn_done = 1'b0;
      set_cfg(3, 3, 2, 1, 0, 0, 1, 2, 0, 0);
      repeat (3) @(negedge clk);
      chk("reset_outputs", {op_valid, busy, done, err, layer_idx, op_w_addr, op_in_addr,
                            op_neuron, op_first, op_last, op_act, op_in_bank}, 0);
      rst = 1'b0;

      set_cfg(3, 3, 2, 1, 0, 0, 1, 2, 0, 0);
      run_cfg(0, 0, 0);
      set_cfg(3, 3, 2, 1, 0, 0, 3, 1, 0, 0);
      run_cfg(1, 0, 0);
      set_cfg(3, 3, 2, 1, 0, 0, 2, 3, 0, 0);
      run_cfg(0, 1, 0);

      set_cfg(3, 3, 0, 1, 0, 0, 0, 0, 0, 0);
      run_bad("nl2_zero");
      set_cfg(6, 1, 1, 1, 1, 1, 0, 0, 0, 0);
      run_bad("nlay6");
      set_cfg(1, 1, 1, 1, 1, 1, 0, 0, 0, 0);
      run_bad("nlay1");
      set_cfg(4, 2, 2, 2, 0, 2, 0, 0, 0, 0);
      run_bad("nl4_zero");
      set_cfg(3, 3, 2, 1, 0, 0, 1, 0, 0, 0);
      run_cfg(2, 0, 0);

      set_cfg(3, 3, 2, 1, 0, 0, 1, 2, 0, 0);
      run_cfg(0, 0, 3);
      set_cfg(3, 3, 2, 1, 0, 0, 1, 2, 0, 0);
      run_cfg(0, 0, 0);

      set_cfg(5, 1, 1, 1, 1, 1, 0, 1, 2, 3);
      run_cfg(0, 0, 0);
      set_cfg(5, 1, 1, 1, 1, 1, 3, 2, 1, 0);
      run_cfg(2, 1, 0);

      repeat (12) begin
         for (int k = 1; k <= 5; k++) nl_t[k] = $urandom_range(1, 4);
         set_cfg($urandom_range(2, 5), nl_t[1], nl_t[2], nl_t[3], nl_t[4], nl_t[5],
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3));
         run_cfg($urandom_range(0, 2), $urandom_range(0, 1), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
